serial_parity_tx: RTL and testbench
===================================

Name: serial_parity_tx

Overview:
- Serial frame transmitter that pairs with the Mealy parity checker.
- Accepts a DATA_W-bit word over a valid/ready handshake and shifts it out LSB-first, one bit per clock.
- Appends one parity bit, so the downstream checker sees a parity-consistent serial stream.
- Sits between a parallel producer and a 1-bit serial link.

Parameters:
- DATA_W, 8: payload bits per frame, legal range ≥1.
- ODD_PARITY, 0: 0 gives even parity, so total ones per frame including parity is even. 1 gives odd parity.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- in_data  input  DATA_W  word to transmit; sampled only at the handshake edge.
- in_valid  input  1  producer has a word.
- in_ready  output  1  transmitter can accept a word this cycle.
- out  output  1  serial bit.
- out_valid  output  1  out carries a frame bit this cycle.
- last  output  1  the current bit is the parity bit.
- state  output  2  FSM state: 0 IDLE, 1 DATA, 2 PARITY.

Behaviour:
- Reset (rst=0, takes effect immediately, no clock needed):
  - state=IDLE; out=0, out_valid=0, last=0.
  - Shift register, bit counter and parity accumulator cleared.
  - in_ready=1.
- All outputs except in_ready are registered. in_ready is combinational: 1 in IDLE or PARITY, 0 in DATA.
- Handshake: a word is accepted on the rising edge where in_valid=1 and in_ready=1. in_data is captured at that edge; later changes to in_data are ignored. in_valid while in_ready=0 is ignored and not queued; the producer holds it.
- FSM:
  - IDLE:
    - accept → DATA; out=in_data[0], out_valid=1.
    - otherwise stay; out=0, out_valid=0.
  - DATA: emit bits 0..DATA_W-1, one per cycle.
    - After bit DATA_W-1 → PARITY; out=parity, last=1.
    - DATA_W=1: DATA lasts exactly one cycle.
  - PARITY: one cycle.
    - accept in the same cycle → DATA with bit0 of the new word next cycle (zero-gap back-to-back).
    - no accept → IDLE; out=0, out_valid=0, last=0.
- Latency: accept at edge T → bit0 valid T..T+1, bit k valid at cycle T+k, parity at cycle T+DATA_W. Frame length is DATA_W+1 cycles.
- Parity: XOR of all DATA_W captured bits, inverted when ODD_PARITY=1. It is computed from the captured word, never from live in_data.
- Bit counter width is $clog2(DATA_W)+1. It wraps to 0 on each new accept.
- out_valid=1 in DATA and PARITY only. last=1 only in PARITY.
- Reset mid-frame: the frame is abandoned, outputs drop immediately and nothing is resumed. The first accept after release starts a clean frame.
- in_valid=1 during reset is ignored. Acceptance is possible on the first edge after rst returns to 1.

Optional Feature:
- Macro PARITY_INJ_EN.
- With it defined:
  - Extra input port inj_err (1 bit), sampled at the handshake edge.
  - If inj_err=1, that frame's parity bit is inverted.
  - Data bits are unaffected, and the injection applies to that frame only.
  - Used to drive parity-error paths in the checker.
- Without it: no inj_err port, and parity is always correct.

Test Plan (DATA_W=4, ODD_PARITY=0 unless stated):
- Reset: drop rst mid-DATA between clock edges → out, out_valid, last=0 and state=0 immediately, before the next edge. in_ready=1.
- Single frame: in_data=4'b1011, in_valid pulse in IDLE → out=1,1,0,1 then 1. out_valid high for exactly 5 cycles, last high on the 5th only, then state=0.
- Even-parity zero case: in_data=4'b0110 → out=0,1,1,0,0. Repeat with ODD_PARITY=1 and 4'b0000 → out=0,0,0,0,1.
- Back-to-back: hold in_valid=1 with 4'b0001 then 4'b1111 → 10 contiguous out_valid cycles, out=1,0,0,0,1,1,1,1,1,0.
  - in_ready low during both DATA phases.
  - Changing in_data during DATA has no effect.
- Reset recovery: rst low during bit 2 of 4'b1010, release, load 4'b0011 → the clean frame 1,1,0,0,0 is emitted with no residue of the old word.
- PARITY_INJ_EN: 4'b1011 with inj_err=1 → parity bit 0. Next frame 4'b1011 with inj_err=0 → parity bit 1.

Source files
------------

// File: rtl/serial_parity_tx.sv
// serial_parity_tx: LSB-first serial frame transmitter with a trailing parity bit; `define PARITY_INJ_EN adds inj_err to force a bad parity bit.
module serial_parity_tx #(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
`ifdef PARITY_INJ_EN
  input  logic              inj_err,
`endif
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out,
  output logic              out_valid,
  output logic              last,
  output logic [1:0]        state
);
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2} state_e;
  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
  state_e            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [CW-1:0]     cnt_q;
  logic              par_q, out_q, out_valid_q, last_q;
  logic              accept, par_d;
  assign in_ready  = state_q != DATA;
  assign accept    = in_valid & in_ready;
`ifdef PARITY_INJ_EN
  assign par_d     = ^in_data ^ ODD_PARITY ^ inj_err;
`else
  assign par_d     = ^in_data ^ ODD_PARITY;
`endif
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign last      = last_q;
  assign state     = state_q;
  // Frame sequencer: capture word and its parity on accept, shift data bits, then emit parity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      par_q       <= 1'b0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end else if (accept) begin
      state_q     <= DATA;
      shift_q     <= in_data >> 1;
      cnt_q       <= '0;
      par_q       <= par_d;
      out_q       <= in_data[0];
      out_valid_q <= 1'b1;
      last_q      <= 1'b0;
    end else if (state_q == DATA) begin
      if (cnt_q == LAST_BIT) begin
        state_q <= PARITY;
        out_q   <= par_q;
        last_q  <= 1'b1;
      end else begin
        cnt_q   <= cnt_q + 1'b1;
        out_q   <= shift_q[0];
        shift_q <= shift_q >> 1;
      end
    end else begin
      state_q     <= IDLE;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end
  end
endmodule

// File: tb/tb_serial_parity_tx.sv
// tb_serial_parity_tx: even and odd parity transmitters driven side by side, checked against literal frames and a bit-queue model.
module tb_serial_parity_tx;
  localparam int W = 4;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
`ifdef PARITY_INJ_EN
  logic inj_err = 1'b0;
`endif
  logic rdy_e, out_e, ov_e, last_e, rdy_o, out_o, ov_o, last_o;
  logic [1:0] st_e, st_o;
  logic [11:0] obs, exp_v;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  serial_parity_tx #(.DATA_W(W), .ODD_PARITY(1'b0)) u_even (
    .clk(clk), .rst(rst),
`ifdef PARITY_INJ_EN
    .inj_err(inj_err),
`endif
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_e),
    .out(out_e), .out_valid(ov_e), .last(last_e), .state(st_e));
  serial_parity_tx #(.DATA_W(W), .ODD_PARITY(1'b1)) u_odd (
    .clk(clk), .rst(rst),
`ifdef PARITY_INJ_EN
    .inj_err(inj_err),
`endif
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_o),
    .out(out_o), .out_valid(ov_o), .last(last_o), .state(st_o));
  assign obs = {ov_e, last_e, st_e, out_e, rdy_e, ov_o, last_o, st_o, out_o, rdy_o};
  function automatic logic [11:0] pack_exp(input logic v, input logic l, input logic [1:0] s,
                                           input logic oe, input logic oo, input logic r);
    return {v, l, s, oe, r, v, l, s, oo, r};
  endfunction
  localparam logic [11:0] IDLE_V = {1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1};
  task automatic test_reset;
    in_valid = 1'b1;
    in_data  = 4'($urandom);
    #1;
    n_cmp++;
    if (obs !== IDLE_V) begin n_err++; $display("FAIL reset_async: got %h want %h", obs, IDLE_V); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== IDLE_V) begin n_err++; $display("FAIL reset_held: got %h want %h", obs, IDLE_V); end
    rst = 1'b1;
    in_valid = 1'b0;
  endtask
  task automatic test_frames;
    logic [3:0] td [3];
    logic [4:0] te [3];
    logic [4:0] tod [3];
    td  = '{4'b1011, 4'b0110, 4'b0000};
    te  = '{5'b11011, 5'b00110, 5'b00000};
    tod = '{5'b01011, 5'b10110, 5'b10000};
    for (int k = 0; k < 3; k++) begin
      in_data  = td[k];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
        in_data = 4'($urandom);
        exp_v = pack_exp(1'b1, i == 4, (i == 4) ? 2'd2 : 2'd1, te[k][i], tod[k][i], i == 4);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL frame%0d bit%0d: got %h want %h", k, i, obs, exp_v); end
        @(posedge clk);
        #1;
      end
      n_cmp++;
      if (obs !== IDLE_V) begin n_err++; $display("FAIL frame%0d idle: got %h want %h", k, obs, IDLE_V); end
    end
  endtask
  task automatic test_back_to_back;
    logic [9:0] se, so;
    se = 10'b0111110001;
    so = 10'b1111100001;
    in_data  = 4'b0001;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_data = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      exp_v = pack_exp(1'b1, i == 4 || i == 9, (i == 4 || i == 9) ? 2'd2 : 2'd1, se[i], so[i], i == 4 || i == 9);
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL b2b cyc%0d: got %h want %h", i, obs, exp_v); end
      if (i >= 5) in_data = 4'($urandom);
      if (i == 9) in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (obs !== IDLE_V) begin n_err++; $display("FAIL b2b idle: got %h want %h", obs, IDLE_V); end
  endtask
  task automatic test_reset_recovery;
    logic [4:0] se, so;
    se = 5'b00011;
    so = 5'b10011;
    in_data  = 4'b1010;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    exp_v = pack_exp(1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL rec_bit2: got %h want %h", obs, exp_v); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (obs !== IDLE_V) begin n_err++; $display("FAIL rec_async: got %h want %h", obs, IDLE_V); end
    in_valid = 1'b1;
    in_data  = 4'($urandom);
    @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== IDLE_V) begin n_err++; $display("FAIL rec_held: got %h want %h", obs, IDLE_V); end
    #2;
    rst = 1'b1;
    in_data = 4'b0011;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_v = pack_exp(1'b1, i == 4, (i == 4) ? 2'd2 : 2'd1, se[i], so[i], i == 4);
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL rec bit%0d: got %h want %h", i, obs, exp_v); end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (obs !== IDLE_V) begin n_err++; $display("FAIL rec idle: got %h want %h", obs, IDLE_V); end
  endtask
`ifdef PARITY_INJ_EN
  task automatic test_inj;
    logic [4:0] te [2];
    logic [4:0] tod [2];
    te  = '{5'b01011, 5'b11011};
    tod = '{5'b11011, 5'b01011};
    for (int k = 0; k < 2; k++) begin
      in_data  = 4'b1011;
      inj_err  = (k == 0);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      inj_err  = (k != 0);
      for (int i = 0; i < 5; i++) begin
        exp_v = pack_exp(1'b1, i == 4, (i == 4) ? 2'd2 : 2'd1, te[k][i], tod[k][i], i == 4);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL inj%0d bit%0d: got %h want %h", k, i, obs, exp_v); end
        @(posedge clk);
        #1;
      end
    end
    inj_err = 1'b0;
  endtask
`endif
  task automatic test_random;
    logic [2:0] q [$];
    logic ready_m, par;
    for (int c = 0; c < 400; c++) begin
      exp_v = (q.size() == 0) ? IDLE_V :
              pack_exp(1'b1, q[0][2], q[0][2] ? 2'd2 : 2'd1, q[0][1], q[0][0], q[0][2]);
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL rand cyc%0d: got %h want %h", c, obs, exp_v); end
      if ($urandom_range(59) == 0) begin
        rst = 1'b0;
        #1;
        q.delete();
        n_cmp++;
        if (obs !== IDLE_V) begin n_err++; $display("FAIL rand_rst cyc%0d: got %h want %h", c, obs, IDLE_V); end
        rst = 1'b1;
      end
      in_valid = $urandom_range(2) != 0;
      in_data  = 4'($urandom);
`ifdef PARITY_INJ_EN
      inj_err  = 1'($urandom);
`endif
      ready_m = q.size() == 0 || q[0][2];
      @(posedge clk);
      if (q.size() != 0) void'(q.pop_front());
      if (in_valid && ready_m) begin
        par = ^in_data;
`ifdef PARITY_INJ_EN
        par = par ^ inj_err;
`endif
        for (int b = 0; b < W; b++) q.push_back({1'b0, in_data[b], in_data[b]});
        q.push_back({1'b1, par, ~par});
      end
      #1;
    end
    in_valid = 1'b0;
  endtask
  initial begin
    test_reset;
    test_frames;
    test_back_to_back;
    test_reset_recovery;
`ifdef PARITY_INJ_EN
    test_inj;
`endif
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
